// File: rtl/io_pkg.sv
// Shared constants and types for the I/O controller.
package io_pkg;

    localparam logic [16:0] ADDR_KEY   = 17'h00100;
    localparam logic [16:0] ADDR_BOMB  = 17'h00104;
    localparam logic [16:0] ADDR_ENEMY = 17'h00108;

    // Bit positions in the KEY and BOMB read words.
    localparam int KEY_VALID_BIT  = 8;
    localparam int BOMB_ARMED_BIT = 16;
    localparam int BOMB_EXPL_BIT  = 17;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } bomb_state_t;

endpackage

// File: rtl/key_fifo.sv
// Keyboard scancode FIFO. The head entry is shown combinationally on dout.
// A push is ignored when full and a pop is ignored when empty.
module key_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    import io_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage next-state.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: keyboard FIFO, bomb countdown timer and
// enemy position register, with everything else forwarded to data memory.
// Load data is combinational so the single-cycle core sees it immediately.
module io_controller #(
    parameter int N          = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TICK_DIV   = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [16:0]  address,
    input  logic         mem_read,
    input  logic         we,
    input  logic [N-1:0] wd,
    input  logic [N-1:0] rdMem,
    output logic [N-1:0] rd,
    output logic         mem_we,
    input  logic         key_valid,
    input  logic [7:0]   key_code,
    output logic         key_ready,
    output logic [N-1:0] enemy_pos,
    output logic         bomb_armed,
    output logic         bomb_irq
);
    import io_pkg::*;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic sel_key, sel_bomb, sel_enemy;
    logic key_pop, key_empty, key_full;
    logic [7:0] key_dout;

    assign sel_key   = (address == ADDR_KEY);
    assign sel_bomb  = (address == ADDR_BOMB);
    assign sel_enemy = (address == ADDR_ENEMY);

    // A simultaneous store suppresses the load side effect.
    assign key_pop   = sel_key && mem_read && !we;
    assign key_ready = !key_full;

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (key_valid && key_ready),
        .pop   (key_pop),
        .din   (key_code),
        .dout  (key_dout),
        .empty (key_empty),
        .full  (key_full)
    );

    bomb_state_t   state_q, state_d;
    logic [15:0]   count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          exploded_q, exploded_d;
    logic          irq_q, irq_d;
    logic [N-1:0]  enemy_q, enemy_d;

    assign bomb_armed = (state_q == ARMED);
    assign bomb_irq   = irq_q;
    assign enemy_pos  = enemy_q;

    // Countdown FSM next-state; a BOMB store overrides any tick or expiry.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        presc_d    = presc_q;
        exploded_d = exploded_q;
        irq_d      = 1'b0;
        if (sel_bomb && mem_read && !we) begin
            exploded_d = 1'b0;
        end
        if (state_q == ARMED) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                count_d = count_q - 1'b1;
                if (count_q == 16'd1) begin
                    state_d    = IDLE;
                    exploded_d = 1'b1;
                    irq_d      = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        if (sel_bomb && we) begin
            count_d    = wd[15:0];
            presc_d    = '0;
            exploded_d = 1'b0;
            irq_d      = 1'b0;
            state_d    = (wd[15:0] != 16'd0) ? ARMED : IDLE;
        end
    end

    // Countdown FSM registers, including the registered expiry pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            presc_q    <= '0;
            exploded_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            exploded_q <= exploded_d;
            irq_q      <= irq_d;
        end
    end

    // ENEMY register next-state.
    always_comb begin
        enemy_d = enemy_q;
        if (sel_enemy && we) enemy_d = wd;
    end

    // ENEMY register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) enemy_q <= '0;
        else       enemy_q <= enemy_d;
    end

    // Read mux and store steering; I/O addresses never reach data memory.
    always_comb begin
        rd     = rdMem;
        mem_we = we;
        if (sel_key) begin
            rd                = '0;
            rd[KEY_VALID_BIT] = !key_empty;
            rd[7:0]           = key_empty ? 8'h00 : key_dout;
            mem_we            = 1'b0;
        end else if (sel_bomb) begin
            rd                 = '0;
            rd[BOMB_EXPL_BIT]  = exploded_q;
            rd[BOMB_ARMED_BIT] = (state_q == ARMED);
            rd[15:0]           = count_q;
            mem_we             = 1'b0;
        end else if (sel_enemy) begin
            rd     = enemy_q;
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with a fast bomb tick.
module tb_io_controller;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [16:0]  address;
    logic         mem_read;
    logic         we;
    logic [N-1:0] wd;
    logic [N-1:0] rdMem;
    logic [N-1:0] rd;
    logic         mem_we;
    logic         key_valid;
    logic [7:0]   key_code;
    logic         key_ready;
    logic [N-1:0] enemy_pos;
    logic         bomb_armed;
    logic         bomb_irq;

    int checks = 0;
    int errors = 0;

    io_controller #(.N(N), .FIFO_DEPTH(4), .TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .mem_read   (mem_read),
        .we         (we),
        .wd         (wd),
        .rdMem      (rdMem),
        .rd         (rd),
        .mem_we     (mem_we),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ready  (key_ready),
        .enemy_pos  (enemy_pos),
        .bomb_armed (bomb_armed),
        .bomb_irq   (bomb_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        address  = 17'h0;
        mem_read = 1'b0;
        we       = 1'b0;
        wd       = '0;
    endtask

    task automatic nclk(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Drive one bus cycle at a negedge; combinational outputs settle after #1.
    task automatic bus(input logic [16:0] a, input logic r, input logic w, input logic [31:0] d);
        address  = a;
        mem_read = r;
        we       = w;
        wd       = d;
        #1;
    endtask

    logic [7:0] codes [4];

    initial begin
        codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h23; codes[3] = 8'h2B;
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        rdMem     = 32'hCAFE0000;
        bus_idle();
        nclk(2);

        // Outputs while reset is held.
        bus(17'h200, 1'b0, 1'b1, 32'h0);
        chk("rst_key_ready", {31'b0, key_ready}, 32'h1);
        chk("rst_armed", {31'b0, bomb_armed}, 32'h0);
        chk("rst_irq", {31'b0, bomb_irq}, 32'h0);
        chk("rst_enemy", enemy_pos, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h1);
        bus(17'h104, 1'b0, 1'b1, 32'h0);
        chk("rst_mem_we_io", {31'b0, mem_we}, 32'h0);
        bus_idle();
        nclk(1);
        reset = 1'b0;
        nclk(1);

        // Empty KEY load and memory/IO store steering.
        bus(17'h100, 1'b1, 1'b0, 32'h0);
        chk("key_empty_rd", rd, 32'h0);
        chk("key_ready0", {31'b0, key_ready}, 32'h1);
        nclk(1);
        bus(17'h200, 1'b0, 1'b1, 32'h55);
        chk("mem_we_mem", {31'b0, mem_we}, 32'h1);
        nclk(1);
        bus(17'h104, 1'b0, 1'b1, 32'h0);
        chk("mem_we_bomb", {31'b0, mem_we}, 32'h0);
        nclk(1);
        bus_idle();

        // Fill, then overflow attempt.
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1;
            key_code  = codes[i];
            nclk(1);
        end
        key_code = 8'h44;
        #1;
        chk("full_ready", {31'b0, key_ready}, 32'h0);
        nclk(1);
        key_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus(17'h100, 1'b1, 1'b0, 32'h0);
            chk($sformatf("key_pop%0d", i), rd, {23'b0, 1'b1, codes[i]});
            nclk(1);
        end
        bus(17'h100, 1'b1, 1'b0, 32'h0);
        chk("key_pop_empty", rd, 32'h0);
        nclk(1);
        bus_idle();

        // Full FIFO with a simultaneous pop: push deferred one cycle.
        for (int i = 1; i <= 4; i++) begin
            key_valid = 1'b1;
            key_code  = 8'(i);
            nclk(1);
        end
        key_code = 8'h44;
        bus(17'h100, 1'b1, 1'b0, 32'h0);
        chk("fullpop_rd", rd, 32'h101);
        chk("fullpop_ready", {31'b0, key_ready}, 32'h0);
        nclk(1);
        bus_idle();
        chk("fullpop_ready_after", {31'b0, key_ready}, 32'h1);
        nclk(1);
        key_valid = 1'b0;
        #1;
        chk("fullpop_refull", {31'b0, key_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus(17'h100, 1'b1, 1'b0, 32'h0);
            chk($sformatf("fullpop_drain%0d", i), rd, (i == 3) ? 32'h144 : 32'(32'h100 + i + 2));
            nclk(1);
        end
        bus_idle();

        // Empty FIFO: simultaneous push and KEY load returns invalid, push lands.
        key_valid = 1'b1;
        key_code  = 8'h5A;
        bus(17'h100, 1'b1, 1'b0, 32'h0);
        chk("empty_push_load", rd, 32'h0);
        nclk(1);
        key_valid = 1'b0;
        bus(17'h100, 1'b1, 1'b0, 32'h0);
        chk("empty_push_after", rd, 32'h15A);
        nclk(1);
        bus_idle();

        // Countdown of 3 ticks at TICK_DIV=4: pulse 12 cycles after the write edge.
        bus(17'h104, 1'b0, 1'b1, 32'h3);
        nclk(1);
        bus_idle();
        chk("bomb_armed", {31'b0, bomb_armed}, 32'h1);
        for (int k = 1; k <= 13; k++) begin
            nclk(1);
            if (k == 5) begin
                bus(17'h104, 1'b0, 1'b0, 32'h0);
                chk("bomb_mid_rd", rd, 32'h10002);
                bus_idle();
            end
            chk($sformatf("bomb_irq_k%0d", k), {31'b0, bomb_irq}, (k == 12) ? 32'h1 : 32'h0);
        end
        chk("bomb_disarmed", {31'b0, bomb_armed}, 32'h0);
        bus(17'h104, 1'b1, 1'b0, 32'h0);
        chk("bomb_rd_expl", rd, 32'h20000);
        nclk(1);
        bus(17'h104, 1'b1, 1'b0, 32'h0);
        chk("bomb_rd_clr", rd, 32'h0);
        nclk(1);
        bus_idle();

        // Cancel a running countdown.
        bus(17'h104, 1'b0, 1'b1, 32'h5);
        nclk(1);
        bus_idle();
        nclk(6);
        bus(17'h104, 1'b0, 1'b1, 32'h0);
        nclk(1);
        bus_idle();
        chk("cancel_armed", {31'b0, bomb_armed}, 32'h0);
        begin
            int irq_seen = 0;
            for (int k = 0; k < 25; k++) begin
                nclk(1);
                if (bomb_irq) irq_seen++;
            end
            chk("cancel_no_irq", 32'(irq_seen), 32'h0);
        end
        bus(17'h104, 1'b0, 1'b0, 32'h0);
        chk("cancel_rd", rd, 32'h0);
        bus_idle();

        // Reset mid-countdown.
        bus(17'h104, 1'b0, 1'b1, 32'h2);
        nclk(1);
        bus_idle();
        nclk(3);
        reset = 1'b1;
        #1;
        chk("rst_mid_armed", {31'b0, bomb_armed}, 32'h0);
        nclk(1);
        reset = 1'b0;
        begin
            int irq_seen = 0;
            for (int k = 0; k < 12; k++) begin
                nclk(1);
                if (bomb_irq) irq_seen++;
            end
            chk("rst_mid_no_irq", 32'(irq_seen), 32'h0);
        end
        bus(17'h104, 1'b0, 1'b0, 32'h0);
        chk("rst_mid_rd", rd, 32'h0);
        bus_idle();

        // ENEMY register and memory pass-through.
        bus(17'h108, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("enemy_mem_we", {31'b0, mem_we}, 32'h0);
        nclk(1);
        bus_idle();
        chk("enemy_pos", enemy_pos, 32'hDEADBEEF);
        bus(17'h108, 1'b1, 1'b0, 32'h0);
        chk("enemy_rd", rd, 32'hDEADBEEF);
        rdMem = 32'h12345678;
        bus(17'h10C, 1'b1, 1'b0, 32'h0);
        chk("mem_passthru", rd, 32'h12345678);
        nclk(1);
        bus_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
